// File: rtl/cpu_trace_pkg.sv
// Shared encodings for the CPU trace line parser: FSM states, grammar
// characters, format codes and error cause codes.
package cpu_trace_pkg;

  // State values double as the err_code reported for a syntax error there.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_TIME = 4'd1,
    S_PC   = 4'd2,
    S_SP_A = 4'd3,
    S_REG  = 4'd4,
    S_ADDR = 4'd5,
    S_SP_B = 4'd6,
    S_LT   = 4'd7,
    S_SP_C = 4'd8,
    S_DATA = 4'd9,
    S_DONE = 4'd10
  } state_t;

  localparam logic [7:0] CH_CARET = 8'h5e;  // '^'
  localparam logic [7:0] CH_AT    = 8'h40;  // '@'
  localparam logic [7:0] CH_COLON = 8'h3a;  // ':'
  localparam logic [7:0] CH_DOLR  = 8'h24;  // '$'
  localparam logic [7:0] CH_STAR  = 8'h2a;  // '*'
  localparam logic [7:0] CH_LT    = 8'h3c;  // '<'
  localparam logic [7:0] CH_EQ    = 8'h3d;  // '='
  localparam logic [7:0] CH_HASH  = 8'h23;  // '#'
  localparam logic [7:0] CH_SPACE = 8'h20;  // ' '

  localparam logic [1:0] FMT_NONE = 2'b00;
  localparam logic [1:0] FMT_REG  = 2'b01;
  localparam logic [1:0] FMT_MEM  = 2'b10;

  localparam logic [3:0] ERR_OVF   = 4'hA;
  localparam logic [3:0] ERR_SEM   = 4'hE;
  localparam logic [3:0] ERR_ABORT = 4'hF;

endpackage

// File: rtl/cpu_trace_parser_char_class.sv
// Combinational character classifier: decimal digit, lowercase hex digit,
// and the 4-bit value of that digit.
module char_class (
  input  logic [7:0] char,
  output logic       is_dec,
  output logic       is_hex,
  output logic [3:0] nibble
);

  logic is_lc;

  always_comb begin
    is_dec = (char >= 8'h30) && (char <= 8'h39);
    is_lc  = (char >= 8'h61) && (char <= 8'h66);
    is_hex = is_dec || is_lc;
    // 'a' is 0x61, so its low nibble plus 9 gives 10.
    if (is_dec)     nibble = char[3:0];
    else if (is_lc) nibble = char[3:0] + 4'd9;
    else            nibble = 4'd0;
  end

endmodule

// File: rtl/cpu_trace_parser.sv
// Byte-serial CPU trace line parser/checker. Define CPU_TRACE_PARSER_CHECK_EN
// to add semantic checks (PC range/alignment, REG<32, ADDR alignment) on '#'.
module cpu_trace_parser
  import cpu_trace_pkg::*;
#(
  parameter int          TIME_DIGITS = 4,
  parameter int          REG_DIGITS  = 4,
  parameter int          HEX_DIGITS  = 8,
  parameter int          CNT_W       = 16,
  parameter logic [31:0] PC_MIN      = 32'h0000_3000,
  parameter logic [31:0] PC_MAX      = 32'h0000_6ffc
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               char,
  output logic [1:0]               format_type,
  output logic [4*TIME_DIGITS-1:0] time_o,
  output logic [4*HEX_DIGITS-1:0]  pc_o,
  output logic [4*HEX_DIGITS-1:0]  idx_o,
  output logic [4*HEX_DIGITS-1:0]  data_o,
  output logic                     err,
  output logic [3:0]               err_code,
  output logic [CNT_W-1:0]         line_cnt
);

  localparam int TW = 4 * TIME_DIGITS;
  localparam int W  = 4 * HEX_DIGITS;
  localparam logic [W-1:0] TEN = W'(10);

  state_t          state, nxt_state;
  logic            nxt_err;
  logic [3:0]      nxt_code;
  logic            bad, ovf, sem_fail, sem_ok;

  logic            is_dec, is_hex;
  logic [3:0]      nib;

  logic [7:0]      cnt;
  logic [TW-1:0]   time_sh;
  logic [W-1:0]    pc_sh, idx_sh, data_sh;
  logic [1:0]      fmt_sh;

  char_class u_cc (
    .char   (char),
    .is_dec (is_dec),
    .is_hex (is_hex),
    .nibble (nib)
  );

`ifdef CPU_TRACE_PARSER_CHECK_EN
  always_comb begin
    sem_ok = (pc_sh[1:0] == 2'b00) && (pc_sh >= PC_MIN) && (pc_sh <= PC_MAX);
    if (fmt_sh == FMT_REG) sem_ok = sem_ok && (idx_sh < W'(32));
    else                   sem_ok = sem_ok && (idx_sh[1:0] == 2'b00);
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{PC_MIN, PC_MAX};
  assign sem_ok = 1'b1;
`endif

  // State and error-pulse register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      err      <= 1'b0;
      err_code <= 4'h0;
    end else begin
      state    <= nxt_state;
      err      <= nxt_err;
      err_code <= nxt_code;
    end
  end

  // Next-state: a '^' always resyncs; otherwise walk the grammar.
  always_comb begin
    nxt_state = state;
    nxt_err   = 1'b0;
    nxt_code  = 4'h0;
    bad       = 1'b0;
    ovf       = 1'b0;
    sem_fail  = 1'b0;
    if (char == CH_CARET) begin
      nxt_state = S_TIME;
      if (state != S_IDLE && state != S_DONE) begin
        nxt_err  = 1'b1;
        nxt_code = ERR_ABORT;
      end
    end else begin
      case (state)
        S_IDLE: nxt_state = S_IDLE;
        S_TIME: begin
          if (is_dec) begin
            if (cnt >= 8'(TIME_DIGITS)) ovf = 1'b1;
          end else if (char == CH_AT && cnt != 8'd0) nxt_state = S_PC;
          else bad = 1'b1;
        end
        S_PC: begin
          if (is_hex) begin
            if (cnt >= 8'(HEX_DIGITS)) ovf = 1'b1;
          end else if (char == CH_COLON && cnt == 8'(HEX_DIGITS)) nxt_state = S_SP_A;
          else bad = 1'b1;
        end
        S_SP_A: begin
          if (char == CH_DOLR)       nxt_state = S_REG;
          else if (char == CH_STAR)  nxt_state = S_ADDR;
          else if (char != CH_SPACE) bad = 1'b1;
        end
        S_REG: begin
          if (is_dec) begin
            if (cnt >= 8'(REG_DIGITS)) ovf = 1'b1;
          end else if (char == CH_SPACE && cnt != 8'd0) nxt_state = S_SP_B;
          else if (char == CH_LT && cnt != 8'd0)        nxt_state = S_LT;
          else bad = 1'b1;
        end
        S_ADDR: begin
          if (is_hex) begin
            if (cnt >= 8'(HEX_DIGITS)) ovf = 1'b1;
          end else if (char == CH_SPACE && cnt == 8'(HEX_DIGITS)) nxt_state = S_SP_B;
          else if (char == CH_LT && cnt == 8'(HEX_DIGITS))        nxt_state = S_LT;
          else bad = 1'b1;
        end
        S_SP_B: begin
          if (char == CH_LT)         nxt_state = S_LT;
          else if (char != CH_SPACE) bad = 1'b1;
        end
        S_LT: begin
          if (char == CH_EQ) nxt_state = S_SP_C;
          else               bad = 1'b1;
        end
        S_SP_C: begin
          if (is_hex)                nxt_state = S_DATA;
          else if (char != CH_SPACE) bad = 1'b1;
        end
        S_DATA: begin
          if (is_hex) begin
            if (cnt >= 8'(HEX_DIGITS)) ovf = 1'b1;
          end else if (char == CH_HASH && cnt == 8'(HEX_DIGITS)) begin
            if (sem_ok) nxt_state = S_DONE;
            else        sem_fail  = 1'b1;
          end else bad = 1'b1;
        end
        S_DONE:  nxt_state = S_IDLE;
        default: nxt_state = S_IDLE;
      endcase
      if (bad || ovf || sem_fail) begin
        nxt_state = S_IDLE;
        nxt_err   = 1'b1;
        if (ovf)           nxt_code = ERR_OVF;
        else if (sem_fail) nxt_code = ERR_SEM;
        else               nxt_code = 4'(state);
      end
    end
  end

  // In-progress field capture; only copied to the outputs on entry to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= 8'd0;
      time_sh <= '0;
      pc_sh   <= '0;
      idx_sh  <= '0;
      data_sh <= '0;
      fmt_sh  <= FMT_NONE;
    end else if (char == CH_CARET) begin
      cnt     <= 8'd0;
      time_sh <= '0;
      pc_sh   <= '0;
      idx_sh  <= '0;
      data_sh <= '0;
      fmt_sh  <= FMT_NONE;
    end else begin
      case (state)
        S_TIME: begin
          if (nxt_state == S_TIME) begin
            time_sh <= {time_sh[TW-5:0], nib};
            cnt     <= cnt + 8'd1;
          end else cnt <= 8'd0;
        end
        S_PC: begin
          if (nxt_state == S_PC) begin
            pc_sh <= {pc_sh[W-5:0], nib};
            cnt   <= cnt + 8'd1;
          end else cnt <= 8'd0;
        end
        S_SP_A: begin
          cnt <= 8'd0;
          if (nxt_state == S_REG)  fmt_sh <= FMT_REG;
          if (nxt_state == S_ADDR) fmt_sh <= FMT_MEM;
        end
        S_REG: begin
          if (nxt_state == S_REG) begin
            idx_sh <= idx_sh * TEN + {{(W-4){1'b0}}, nib};
            cnt    <= cnt + 8'd1;
          end
        end
        S_ADDR: begin
          if (nxt_state == S_ADDR) begin
            idx_sh <= {idx_sh[W-5:0], nib};
            cnt    <= cnt + 8'd1;
          end
        end
        S_SP_C: begin
          if (nxt_state == S_DATA) begin
            data_sh <= {{(W-4){1'b0}}, nib};
            cnt     <= 8'd1;
          end
        end
        S_DATA: begin
          if (nxt_state == S_DATA) begin
            data_sh <= {data_sh[W-5:0], nib};
            cnt     <= cnt + 8'd1;
          end
        end
        default: cnt <= cnt;
      endcase
    end
  end

  // Accepted-line outputs and saturating counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_o   <= '0;
      pc_o     <= '0;
      idx_o    <= '0;
      data_o   <= '0;
      line_cnt <= '0;
    end else if (nxt_state == S_DONE && state == S_DATA) begin
      time_o <= time_sh;
      pc_o   <= pc_sh;
      idx_o  <= idx_sh;
      data_o <= data_sh;
      if (line_cnt != {CNT_W{1'b1}}) line_cnt <= line_cnt + CNT_W'(1);
    end
  end

  // fmt_sh is untouched during DONE, so it still describes the finished line.
  always_comb begin
    format_type = FMT_NONE;
    if (state == S_DONE) format_type = fmt_sh;
  end

endmodule
